// File: rtl/decode_prefetch_queue_if.sv
// Fetch-side and decode-side signal bundle for decode_prefetch_queue.
// The queue uses the slave modport; the fetch/decode driver uses master.
interface decode_prefetch_queue_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          i_flush;
    logic          i_fetch_valid;
    logic          o_fetch_ready;
    logic [31:0]   i_fetch_data;
    logic [2:0]    i_fetch_count;
    logic [7:0]    o_window [0:3];
    logic [3:0]    o_window_valid;
    logic [2:0]    i_consume_count;
    logic [LW-1:0] o_level;
    logic          o_empty;
    logic          o_underflow;

    modport slave (
        input  i_flush, i_fetch_valid, i_fetch_data, i_fetch_count, i_consume_count,
        output o_fetch_ready, o_window, o_window_valid, o_level, o_empty, o_underflow
    );

    modport master (
        output i_flush, i_fetch_valid, i_fetch_data, i_fetch_count, i_consume_count,
        input  o_fetch_ready, o_window, o_window_valid, o_level, o_empty, o_underflow
    );
endinterface

// File: rtl/decode_prefetch_queue.sv
// Byte-granular instruction prefetch queue presenting a 4-byte window to decode.
// Optional same-cycle fetch-to-window bypass: define PREFETCH_QUEUE_BYPASS_EN.
module decode_prefetch_queue #(
    parameter int DEPTH  = 16,
    parameter int WINDOW = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    decode_prefetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [7:0]    r_buf [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [LW-1:0] r_level;
    logic          r_underflow;
    logic          r_run;

    logic          w_count_ok;
    logic          w_accept;
    logic [2:0]    w_acc_count;
    logic [LW-1:0] w_consume;
    logic [LW-1:0] w_avail;
    logic [LW-1:0] w_eff;
    logic [LW-1:0] w_level_next;
    logic          w_underflow;

    assign w_count_ok  = (bus.i_fetch_count != 3'd0) && (bus.i_fetch_count <= 3'd4);
    // Ready looks only at the registered level, so it never depends on this cycle's consume.
    assign bus.o_fetch_ready = r_run && ((LW'(DEPTH) - r_level) >= LW'(4));
    assign w_accept    = bus.i_fetch_valid && bus.o_fetch_ready && w_count_ok;
    assign w_acc_count = w_accept ? bus.i_fetch_count : 3'd0;
    assign w_consume   = LW'(bus.i_consume_count);

`ifdef PREFETCH_QUEUE_BYPASS_EN
    logic w_bypass;
    assign w_bypass = w_accept && !bus.i_flush && (r_level < LW'(4));
    assign w_avail  = w_bypass ? (r_level + LW'(w_acc_count)) : r_level;
`else
    assign w_avail  = r_level;
`endif

    assign w_underflow  = w_consume > w_avail;
    assign w_eff        = w_underflow ? w_avail : w_consume;
    assign w_level_next = r_level - w_eff + LW'(w_acc_count);

    // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_level     <= '0;
            r_underflow <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (bus.i_flush) begin
                r_rd_ptr    <= '0;
                r_wr_ptr    <= '0;
                r_level     <= '0;
                r_underflow <= 1'b0;
            end else begin
                r_wr_ptr <= r_wr_ptr + PW'(w_acc_count);
                r_rd_ptr <= r_rd_ptr + PW'(w_eff);
                r_level  <= w_level_next;
                if (w_underflow) r_underflow <= 1'b1;
            end
        end
    end

    // NOTE: the byte store has no reset; pointers and level alone decide which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_accept && !bus.i_flush) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < bus.i_fetch_count)
                    r_buf[r_wr_ptr + PW'(k)] <= bus.i_fetch_data[8*k +: 8];
            end
        end
    end

    // NOTE: every window output gets a default first so no latch is inferred.
    always_comb begin
`ifdef PREFETCH_QUEUE_BYPASS_EN
        logic [2:0] v_off;
        v_off = 3'd0;
`endif
        for (int k = 0; k < WINDOW; k++) begin
            bus.o_window[k]       = 8'h00;
            bus.o_window_valid[k] = 1'b0;
            if (r_level > LW'(k)) begin
                bus.o_window[k]       = r_buf[r_rd_ptr + PW'(k)];
                bus.o_window_valid[k] = 1'b1;
            end
`ifdef PREFETCH_QUEUE_BYPASS_EN
            else begin
                // Empty lanes take fetch bytes in order, starting at byte0.
                v_off = 3'(k) - r_level[2:0];
                if (w_bypass && (v_off < w_acc_count)) begin
                    bus.o_window[k]       = bus.i_fetch_data[{v_off[1:0], 3'b000} +: 8];
                    bus.o_window_valid[k] = 1'b1;
                end
            end
`endif
        end
    end

    assign bus.o_level     = r_level;
    assign bus.o_empty     = (r_level == '0);
    assign bus.o_underflow = r_underflow;
endmodule

// File: tb/tb_decode_prefetch_queue.sv
// Directed self-checking bench for decode_prefetch_queue with a byte-queue scoreboard.
// Honours PREFETCH_QUEUE_BYPASS_EN when the design is built with it.
module tb_decode_prefetch_queue;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;

    decode_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

    decode_prefetch_queue #(.DEPTH(DEPTH), .WINDOW(4)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    bit         exp_uf   = 1'b0;
    bit         exp_run  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] gen(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic set_in(input bit fv, input logic [31:0] d, input logic [2:0] cnt,
                          input logic [2:0] cons, input bit fl);
        bus.i_fetch_valid   = fv;
        bus.i_fetch_data    = d;
        bus.i_fetch_count   = cnt;
        bus.i_consume_count = cons;
        bus.i_flush         = fl;
    endtask

    // Advance one clock, updating the byte-queue scoreboard with what was offered.
    task automatic clock();
        int n;
        int avail;
        int eff;
        bit acc;
        @(posedge clk);
        n   = exp_q.size();
        acc = bus.i_fetch_valid && exp_run && ((DEPTH - n) >= 4) &&
              (bus.i_fetch_count >= 3'd1) && (bus.i_fetch_count <= 3'd4);
        if (bus.i_flush) begin
            exp_q.delete();
            exp_uf = 1'b0;
        end else begin
            avail = n;
            if (acc) begin
                for (int k = 0; k < int'(bus.i_fetch_count); k++)
                    exp_q.push_back(bus.i_fetch_data[8*k +: 8]);
`ifdef PREFETCH_QUEUE_BYPASS_EN
                if (n < 4) avail = n + int'(bus.i_fetch_count);
`endif
            end
            eff = (int'(bus.i_consume_count) > avail) ? avail : int'(bus.i_consume_count);
            if (int'(bus.i_consume_count) > avail) exp_uf = 1'b1;
            repeat (eff) void'(exp_q.pop_front());
        end
        exp_run = 1'b1;
        @(negedge clk);
        set_in(1'b0, 32'h0, 3'd0, 3'd0, 1'b0);
    endtask

    task automatic check_state(input string tag);
        int         n;
        logic [3:0] vld;
        n = exp_q.size();
        vld = 4'b0000;
        for (int k = 0; k < 4; k++) if (k < n) vld[k] = 1'b1;
        chk({tag, ".level"},     32'(bus.o_level), 32'(n));
        chk({tag, ".empty"},     32'(bus.o_empty), 32'(n == 0));
        chk({tag, ".underflow"}, 32'(bus.o_underflow), 32'(exp_uf));
        chk({tag, ".ready"},     32'(bus.o_fetch_ready), 32'(exp_run && ((DEPTH - n) >= 4)));
        chk({tag, ".valid"},     32'(bus.o_window_valid), 32'(vld));
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s.win%0d", tag, k), 32'(bus.o_window[k]),
                (k < n) ? 32'(exp_q[k]) : 32'h0);
    endtask

    task automatic step(input string tag, input bit fv, input logic [31:0] d,
                        input logic [2:0] cnt, input logic [2:0] cons, input bit fl);
        set_in(fv, d, cnt, cons, fl);
        clock();
        check_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_word;
        logic [3:0]  exp_vld;

        // Reset with a fetch already being offered
        rst_n = 1'b0;
        set_in(1'b1, 32'hDEADBEEF, 3'd4, 3'd0, 1'b0);
        @(negedge clk);
        check_state("reset");
        rst_n = 1'b1;
        set_in(1'b0, 32'h0, 3'd0, 3'd0, 1'b0);
        clock();
        check_state("post_reset");

        step("t1_fetch", 1'b1, 32'h44332211, 3'd4, 3'd0, 1'b0);

        // Fill to DEPTH, then a fetch while full is refused
        step("fill1", 1'b1, gen(8'h50), 3'd4, 3'd0, 1'b0);
        step("fill2", 1'b1, gen(8'h60), 3'd4, 3'd0, 1'b0);
        step("full",  1'b1, gen(8'h70), 3'd4, 3'd0, 1'b0);
        step("full_refuse", 1'b1, gen(8'h80), 3'd4, 3'd0, 1'b0);
        step("full_consume", 1'b0, 32'h0, 3'd0, 3'd4, 1'b0);

        // Move the read pointer to 14 so the window straddles 15 -> 0
        step("drain1", 1'b0, 32'h0, 3'd0, 3'd4, 1'b0);
        step("drain2", 1'b0, 32'h0, 3'd0, 3'd4, 1'b0);
        step("drain3", 1'b0, 32'h0, 3'd0, 3'd2, 1'b0);
        step("wrap_fetch", 1'b1, gen(8'h90), 3'd4, 3'd0, 1'b0);
        step("wrap_fill1", 1'b1, gen(8'hA0), 3'd4, 3'd0, 1'b0);
        step("wrap_fill2", 1'b1, gen(8'hB0), 3'd4, 3'd0, 1'b0);
        step("lvl14_fc", 1'b1, gen(8'hC0), 3'd4, 3'd3, 1'b0);
        step("lvl11_fc", 1'b1, gen(8'hC0), 3'd4, 3'd3, 1'b0);

        // Underflow is sticky until flush; partial and illegal fetch counts
        step("u_drain1", 1'b0, 32'h0, 3'd0, 3'd4, 1'b0);
        step("u_drain2", 1'b0, 32'h0, 3'd0, 3'd4, 1'b0);
        step("u_drain3", 1'b0, 32'h0, 3'd0, 3'd2, 1'b0);
        step("underflow", 1'b0, 32'h0, 3'd0, 3'd3, 1'b0);
        step("uf_sticky", 1'b0, 32'h0, 3'd0, 3'd0, 1'b0);
        step("partial3", 1'b1, gen(8'hD0), 3'd3, 3'd0, 1'b0);
        step("count0", 1'b1, gen(8'hE0), 3'd0, 3'd0, 1'b0);
        step("count5", 1'b1, gen(8'hE0), 3'd5, 3'd0, 1'b0);
        step("flush_uf", 1'b0, 32'h0, 3'd0, 3'd0, 1'b1);

        // Flush beats a simultaneous fetch and consume; the next fetch is taken
        step("pre_flush", 1'b1, gen(8'hE4), 3'd4, 3'd0, 1'b0);
        step("flush_busy", 1'b1, gen(8'hF0), 3'd4, 3'd2, 1'b1);
        step("after_flush", 1'b1, 32'h04030201, 3'd4, 3'd0, 1'b0);
        step("flush2", 1'b0, 32'h0, 3'd0, 3'd0, 1'b1);

        // Same-cycle window on an empty queue
        set_in(1'b1, 32'hF0662EF3, 3'd4, 3'd0, 1'b0);
        #1;
`ifdef PREFETCH_QUEUE_BYPASS_EN
        exp_word = 32'hF0662EF3;
        exp_vld  = 4'b1111;
`else
        exp_word = 32'h0;
        exp_vld  = 4'b0000;
`endif
        chk("bypass.valid", 32'(bus.o_window_valid), 32'(exp_vld));
        for (int k = 0; k < 4; k++)
            chk($sformatf("bypass.win%0d", k), 32'(bus.o_window[k]), 32'(exp_word[8*k +: 8]));
        clock();
        check_state("bypass_next");
        step("flush3", 1'b0, 32'h0, 3'd0, 3'd0, 1'b1);
        step("bypass_consume", 1'b1, 32'h00002211, 3'd2, 3'd1, 1'b0);
        step("flush4", 1'b0, 32'h0, 3'd0, 3'd0, 1'b1);

        // Reset in the middle of traffic discards everything
        step("mid_fill", 1'b1, gen(8'h30), 3'd4, 3'd0, 1'b0);
        set_in(1'b1, gen(8'h40), 3'd4, 3'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_uf  = 1'b0;
        exp_run = 1'b0;
        #1;
        check_state("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b0, 32'h0, 3'd0, 3'd0, 1'b0);
        clock();
        check_state("mid_release");
        step("mid_refetch", 1'b1, gen(8'h48), 3'd4, 3'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
